// File: rtl/wishbone_arbiter2.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter2
//
// Two-master Wishbone arbiter that sits between the OpenMIPS data port
// (master D) and instruction-fetch port (master I) and the single slave port of
// the bus fabric. Ownership is granted round-robin and held for the whole cyc
// transaction. A watchdog aborts any access that the slave never acknowledges,
// so a hung peripheral cannot stall the pipeline forever.
//
// Parameters
//   TIMEOUT    consecutive unacknowledged strobe cycles before an abort
//              (1..65535)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   md_*_i     master D request: cyc, stb, we, addr[31:0], data[31:0], sel[3:0]
//   md_*_o     master D response: data[31:0], ack, err (timeout)
//   mi_*_i     master I request (same set as master D)
//   mi_*_o     master I response (same set as master D)
//   s_*_o      slave request: cyc, stb, we, addr[31:0], data[31:0], sel[3:0]
//   s_data_i   slave read data
//   s_ack_i    slave acknowledge
//   grant_o    current owner: 00 none / abort, 01 D, 10 I
// -----------------------------------------------------------------------------
module wishbone_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        md_cyc_i,
    input  logic        md_stb_i,
    input  logic        md_we_i,
    input  logic [31:0] md_addr_i,
    input  logic [31:0] md_data_i,
    input  logic [3:0]  md_sel_i,
    output logic [31:0] md_data_o,
    output logic        md_ack_o,
    output logic        md_err_o,

    input  logic        mi_cyc_i,
    input  logic        mi_stb_i,
    input  logic        mi_we_i,
    input  logic [31:0] mi_addr_i,
    input  logic [31:0] mi_data_i,
    input  logic [3:0]  mi_sel_i,
    output logic [31:0] mi_data_o,
    output logic        mi_ack_o,
    output logic        mi_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OWN_D   = 3'd1,
        ST_OWN_I   = 3'd2,
        ST_ABORT_D = 3'd3,
        ST_ABORT_I = 3'd4
    } state_t;

    // Counter value seen during the TIMEOUT-th consecutive stalled strobe.
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_i;      // 1: most recent owner was I, 0: was D
    logic        w_last_i_nxt;
    logic [15:0] r_tcnt;
    logic [15:0] w_tcnt_nxt;

    logic        w_own_d;
    logic        w_own_i;
    logic        w_owner_cyc;
    logic        w_stall;
    logic        w_timeout;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_last_i <= 1'b1;       // D wins the first tie
            r_tcnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_i <= w_last_i_nxt;
            r_tcnt   <= w_tcnt_nxt;
        end
    end

    assign w_own_d = (r_state == ST_OWN_D);
    assign w_own_i = (r_state == ST_OWN_I);

    // -------------------------------------------------------------------------
    // Slave-side routing: owner's request passes straight through; IDLE and
    // ABORT states present an all-zero request to the slave.
    // -------------------------------------------------------------------------
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        if (w_own_d) begin
            s_cyc_o  = md_cyc_i;
            s_stb_o  = md_stb_i;
            s_we_o   = md_we_i;
            s_addr_o = md_addr_i;
            s_data_o = md_data_i;
            s_sel_o  = md_sel_i;
        end else if (w_own_i) begin
            s_cyc_o  = mi_cyc_i;
            s_stb_o  = mi_stb_i;
            s_we_o   = mi_we_i;
            s_addr_o = mi_addr_i;
            s_data_o = mi_data_i;
            s_sel_o  = mi_sel_i;
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog: an ack in the final cycle wins, since w_stall is then low.
    // -------------------------------------------------------------------------
    assign w_owner_cyc = (w_own_d & md_cyc_i) | (w_own_i & mi_cyc_i);
    assign w_stall     = s_stb_o & ~s_ack_i;
    assign w_timeout   = w_owner_cyc & w_stall & (r_tcnt == TCNT_LAST);

    // -------------------------------------------------------------------------
    // Master-side routing: only the current owner sees ack/data/err.
    // -------------------------------------------------------------------------
    assign md_ack_o  = w_own_d & s_ack_i;
    assign md_data_o = w_own_d ? s_data_i : '0;
    assign md_err_o  = w_own_d & w_timeout;

    assign mi_ack_o  = w_own_i & s_ack_i;
    assign mi_data_o = w_own_i ? s_data_i : '0;
    assign mi_err_o  = w_own_i & w_timeout;

    assign grant_o   = {w_own_i, w_own_d};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_last_i_nxt = r_last_i;
        w_tcnt_nxt   = '0;

        case (r_state)
            ST_IDLE: begin
                // On a tie, D wins only if I was the previous owner.
                if (md_cyc_i && (!mi_cyc_i || r_last_i)) begin
                    w_state_nxt  = ST_OWN_D;
                    w_last_i_nxt = 1'b0;
                end else if (mi_cyc_i) begin
                    w_state_nxt  = ST_OWN_I;
                    w_last_i_nxt = 1'b1;
                end
            end

            ST_OWN_D: begin
                if (!md_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT_D;
                end else if (w_stall) begin
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end

            ST_OWN_I: begin
                if (!mi_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ABORT_I;
                end else if (w_stall) begin
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end

            // The aborted master keeps the bus locked until it drops cyc.
            ST_ABORT_D: begin
                if (!md_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_ABORT_I: begin
                if (!mi_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wishbone_arbiter2
//
// Self-checking bench for wishbone_arbiter2 (TIMEOUT = 8). Two random masters
// and a random slave drive the arbiter; every cycle all outputs are compared
// with a behavioural model of ownership, round-robin history and stall count.
// Directed segments cover reset, a waited read, a timeout and a mid-access
// reset.
// -----------------------------------------------------------------------------
module tb_wishbone_arbiter2;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        md_cyc_i, md_stb_i, md_we_i;
    logic [31:0] md_addr_i, md_data_i;
    logic [3:0]  md_sel_i;
    logic [31:0] md_data_o;
    logic        md_ack_o, md_err_o;

    logic        mi_cyc_i, mi_stb_i, mi_we_i;
    logic [31:0] mi_addr_i, mi_data_i;
    logic [3:0]  mi_sel_i;
    logic [31:0] mi_data_o;
    logic        mi_ack_o, mi_err_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    // Master request registers, index 0 = D, 1 = I
    logic        cyc_v  [2];
    logic        stb_v  [2];
    logic        we_v   [2];
    logic [31:0] addr_v [2];
    logic [31:0] wdat_v [2];
    logic [3:0]  sel_v  [2];

    assign md_cyc_i  = cyc_v[0];
    assign md_stb_i  = stb_v[0];
    assign md_we_i   = we_v[0];
    assign md_addr_i = addr_v[0];
    assign md_data_i = wdat_v[0];
    assign md_sel_i  = sel_v[0];
    assign mi_cyc_i  = cyc_v[1];
    assign mi_stb_i  = stb_v[1];
    assign mi_we_i   = we_v[1];
    assign mi_addr_i = addr_v[1];
    assign mi_data_i = wdat_v[1];
    assign mi_sel_i  = sel_v[1];

    wishbone_arbiter2 #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .md_cyc_i  (md_cyc_i),
        .md_stb_i  (md_stb_i),
        .md_we_i   (md_we_i),
        .md_addr_i (md_addr_i),
        .md_data_i (md_data_i),
        .md_sel_i  (md_sel_i),
        .md_data_o (md_data_o),
        .md_ack_o  (md_ack_o),
        .md_err_o  (md_err_o),
        .mi_cyc_i  (mi_cyc_i),
        .mi_stb_i  (mi_stb_i),
        .mi_we_i   (mi_we_i),
        .mi_addr_i (mi_addr_i),
        .mi_data_i (mi_data_i),
        .mi_sel_i  (mi_sel_i),
        .mi_data_o (mi_data_o),
        .mi_ack_o  (mi_ack_o),
        .mi_err_o  (mi_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: owner 0 none / 1 D / 2 I, abort flag, last owner,
    // number of consecutive stalled strobe cycles already completed.
    // -------------------------------------------------------------------------
    int m_owner;
    bit m_abort;
    int m_last;
    int m_wait;
    bit e_ack [2];
    bit e_err [2];

    task automatic model_reset();
        m_owner = 0;
        m_abort = 1'b0;
        m_last  = 2;
        m_wait  = 0;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_err[0] = 1'b0; e_err[1] = 1'b0;
    endtask

    function automatic bit own_cyc();
        if (m_owner == 1) return md_cyc_i;
        if (m_owner == 2) return mi_cyc_i;
        return 1'b0;
    endfunction

    function automatic bit own_stb();
        if (m_owner == 1) return md_stb_i;
        if (m_owner == 2) return mi_stb_i;
        return 1'b0;
    endfunction

    // The T-th consecutive stalled strobe cycle without ack triggers the abort.
    function automatic bit model_err();
        if (m_owner == 0 || m_abort) return 1'b0;
        return own_cyc() && own_stb() && !s_ack_i && (m_wait == T - 1);
    endfunction

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (md_cyc_i && mi_cyc_i) m_owner = (m_last == 1) ? 2 : 1;
            else if (md_cyc_i)        m_owner = 1;
            else if (mi_cyc_i)        m_owner = 2;
            if (m_owner != 0) m_last = m_owner;
            m_wait = 0;
        end else if (m_abort) begin
            if (!own_cyc()) begin
                m_owner = 0;
                m_abort = 1'b0;
            end
        end else if (!own_cyc()) begin
            m_owner = 0;
            m_wait  = 0;
        end else if (model_err()) begin
            m_abort = 1'b1;
            m_wait  = 0;
        end else if (own_stb() && !s_ack_i) begin
            m_wait++;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic check_all();
        logic [70:0] es;
        logic [33:0] ed;
        logic [33:0] ei;
        logic [1:0]  eg;
        bit          live;
        bit          err;
        #1;
        es = '0; ed = '0; ei = '0; eg = 2'b00;
        e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_err[0] = 1'b0; e_err[1] = 1'b0;
        live = (m_owner != 0) && !m_abort;
        if (live) begin
            err = model_err();
            if (m_owner == 1) begin
                es = {md_cyc_i, md_stb_i, md_we_i, md_addr_i, md_data_i, md_sel_i};
                ed = {s_data_i, s_ack_i, err};
                eg = 2'b01;
                e_ack[0] = s_ack_i; e_err[0] = err;
            end else begin
                es = {mi_cyc_i, mi_stb_i, mi_we_i, mi_addr_i, mi_data_i, mi_sel_i};
                ei = {s_data_i, s_ack_i, err};
                eg = 2'b10;
                e_ack[1] = s_ack_i; e_err[1] = err;
            end
        end
        check_eq("slave_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o}), 128'(es));
        check_eq("md_resp",   128'({md_data_o, md_ack_o, md_err_o}), 128'(ed));
        check_eq("mi_resp",   128'({mi_data_o, mi_ack_o, mi_err_o}), 128'(ei));
        check_eq("grant",     128'(grant_o), 128'(eg));
    endtask

    // Advance one clock: model follows the edge, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Random masters and slave
    // -------------------------------------------------------------------------
    int left     [2];
    int hold     [2];
    bit aborting [2];

    task automatic new_req(input int m);
        stb_v[m]  = 1'b1;
        we_v[m]   = 1'($urandom);
        addr_v[m] = $urandom;
        wdat_v[m] = $urandom;
        sel_v[m]  = 4'($urandom);
    endtask

    task automatic drop(input int m);
        cyc_v[m] = 1'b0;
        stb_v[m] = 1'b0;
    endtask

    task automatic drive_master(input int m, input bit ack, input bit err);
        if (!cyc_v[m]) begin
            if ($urandom_range(0, 3) == 0) begin
                cyc_v[m]    = 1'b1;
                left[m]     = int'($urandom_range(1, 4));
                aborting[m] = 1'b0;
                new_req(m);
            end
        end else if (aborting[m]) begin
            if (hold[m] == 0) drop(m);
            else hold[m]--;
        end else if (err) begin
            aborting[m] = 1'b1;
            hold[m]     = int'($urandom_range(0, 2));
            if (hold[m] == 0) drop(m);
        end else if ($urandom_range(0, 63) == 0) begin
            drop(m);
        end else if (ack) begin
            left[m]--;
            if (left[m] == 0) drop(m);
            else new_req(m);
        end
    endtask

    task automatic clear_masters();
        for (int m = 0; m < 2; m++) begin
            drop(m);
            we_v[m] = 1'b0; addr_v[m] = '0; wdat_v[m] = '0; sel_v[m] = '0;
            left[m] = 0; hold[m] = 0; aborting[m] = 1'b0;
        end
    endtask

    initial begin
        int ack_pct;
        bit pa0, pe0, pa1, pe1;

        rst = 1'b1;
        clear_masters();
        s_ack_i  = 1'b0;
        s_data_i = '0;
        model_reset();
        #1 rst = 1'b0;

        // Reset with both masters requesting and a stray ack.
        #2;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; addr_v[0] = 32'h0000_0010;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; addr_v[1] = 32'h0000_0100;
        s_ack_i  = 1'b1; s_data_i = 32'h1234_5678;
        check_all();
        tick();
        check_all();
        tick();
        s_ack_i = 1'b0;
        rst = 1'b1;
        check_all();
        tick();
        check_eq("first_grant", 128'(grant_o), 128'(2'b01));

        // D read at 0x10 with two wait states.
        check_all();
        tick();
        check_all();
        tick();
        s_ack_i  = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        check_all();
        check_eq("d_read", 128'({md_ack_o, md_data_o}), 128'({1'b1, 32'hDEAD_BEEF}));
        check_eq("d_read_mi_ack", 128'(mi_ack_o), 128'(1'b0));
        tick();
        s_ack_i = 1'b0;
        drop(0);
        check_all();

        // Randomized traffic with increasingly unresponsive slave.
        tick();
        clear_masters();
        check_all();
        for (int c = 0; c < 3000; c++) begin
            ack_pct = (c < 1200) ? 40 : (c < 2200) ? 8 : 0;
            pa0 = e_ack[0]; pe0 = e_err[0];
            pa1 = e_ack[1]; pe1 = e_err[1];
            tick();
            drive_master(0, pa0, pe0);
            drive_master(1, pa1, pe1);
            s_ack_i  = ($urandom_range(0, 99) < ack_pct);
            s_data_i = $urandom;
            check_all();
        end

        // Timeout on I while D waits.
        tick();
        clear_masters();
        s_ack_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_all();
            tick();
        end
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; addr_v[1] = 32'h0000_2000;
        check_all();
        tick();
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; addr_v[0] = 32'h0000_3000;
        for (int k = 1; k <= T; k++) begin
            check_all();
            check_eq("timeout_err", 128'(mi_err_o), 128'(k == T));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            check_all();
            check_eq("abort_grant", 128'(grant_o), 128'(2'b00));
            tick();
        end
        drop(1);
        check_all();
        tick();
        check_eq("after_abort_idle", 128'(grant_o), 128'(2'b00));
        check_all();
        tick();
        check_eq("after_abort_d", 128'(grant_o), 128'(2'b01));
        check_all();

        // Reset during an I access with ack pending.
        drop(0);
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; addr_v[1] = 32'h0000_4000;
        tick();
        check_all();
        tick();
        check_all();
        #2 rst = 1'b0;
        model_reset();
        check_all();
        check_eq("rst_async", 128'({s_cyc_o, s_stb_o, grant_o, mi_ack_o, mi_err_o, mi_data_o}), 128'(0));
        tick();
        clear_masters();
        s_ack_i  = 1'b1;
        s_data_i = 32'hCAFE_F00D;
        check_all();
        tick();
        rst = 1'b1;
        check_all();
        tick();
        check_all();
        check_eq("stray_ack", 128'({md_ack_o, mi_ack_o}), 128'(2'b00));
        s_ack_i = 1'b0;
        tick();
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_arbiter2.md
# wishbone_arbiter2

Two-master Wishbone arbiter placed between the OpenMIPS core's data port (master D) and instruction-fetch port (master I) and the single slave port of the bus fabric (SRAM, flash, UART, segment display). It grants the shared bus to one master at a time using round-robin arbitration. The grant is held for the whole `cyc` transaction. A watchdog terminates slave accesses that never acknowledge, so a hung peripheral cannot stall the pipeline forever.

## Interface
- `TIMEOUT`, default 255: number of consecutive unacknowledged strobe cycles after which an access is aborted (1..65535).
- `clk` input 1: system clock (the CPU clock domain).
- `rst` input 1: asynchronous, active-low reset.
- `md_cyc_i`, `md_stb_i`, `md_we_i` input 1 each: master D cycle, strobe and write-enable.
- `md_addr_i` input 32: master D address.
- `md_data_i` input 32: master D write data.
- `md_sel_i` input 4: master D byte selects.
- `md_data_o` output 32: master D read data.
- `md_ack_o` output 1: master D acknowledge.
- `md_err_o` output 1: master D timeout error.
- `mi_*`: the same nine ports for master I.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each: slave cycle, strobe and write-enable.
- `s_addr_o` output 32: slave address.
- `s_data_o` output 32: slave write data.
- `s_sel_o` output 4: slave byte selects.
- `s_data_i` input 32: slave read data.
- `s_ack_i` input 1: slave acknowledge.
- `grant_o` output 2: current owner (00 = none, 01 = D, 10 = I).

## Operation
- States:
  - IDLE: no owner.
  - OWN_D: master D owns the bus.
  - OWN_I: master I owns the bus.
- Registers:
  - state, initial IDLE.
  - `last` (1 bit), the most recent owner; resets to I so that D wins the first tie.
  - `tcnt` (16-bit watchdog counter).
- Transitions out of IDLE (requests are `md_cyc_i` and `mi_cyc_i`):
  - Only D requesting: go to OWN_D.
  - Only I requesting: go to OWN_I.
  - Both requesting: grant the master that is not `last`.
  - On entering an OWN state, set `last` to that master.
- OWN_x with the owner's `cyc_i` still high: stay in OWN_x. One master may issue several strobes (back-to-back or burst) without re-arbitration.
- OWN_x with the owner's `cyc_i` low: return to IDLE. The other master is considered in the IDLE cycle.
- Slave-side routing:
  - In OWN_x, `s_cyc_o`/`s_stb_o`/`s_we_o`/`s_addr_o`/`s_data_o`/`s_sel_o` are combinational copies of the owner's inputs.
  - In IDLE, all slave outputs are 0.
- Master-side routing:
  - The owner's `ack_o` = `s_ack_i` and its `data_o` = `s_data_i`.
  - The non-owner sees `ack_o` = 0 and `data_o` = 0.
  - A stray `s_ack_i` in IDLE is dropped.
- Watchdog counting:
  - In OWN_x, `tcnt` increments each cycle that `s_stb_o`=1 and `s_ack_i`=0.
  - It clears on `s_ack_i`=1, on stb low, and in IDLE.
- Watchdog abort, when `tcnt` reaches `TIMEOUT`-1 and there is still no ack:
  - The owner's `err_o` pulses for exactly one cycle (combinational in that cycle).
  - On the next edge the FSM goes to ABORT_x and `tcnt` clears.
- ABORT_x state:
  - Slave outputs are forced to 0.
  - The FSM waits there until the owner drops `cyc_i`, then returns to IDLE.
  - The other master is not granted while in ABORT_x.
- `err_o` is 0 in all other cases.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE, `last` = I, `tcnt` = 0.
  - All `s_*` outputs are 0, `grant_o` = 00, and all `ack_o`/`err_o`/`data_o` are 0.
- Reset asserted mid-transaction aborts the access immediately, with no ack and no err.
- Grant latency: a `cyc_i` seen in IDLE at edge N gives ownership after edge N. `s_stb_o` is visible during cycle N+1.
- Ack latency through the arbiter is zero cycles (combinational).
- Handover: the owner drops `cyc_i` in cycle K, the FSM is in IDLE in K+1, and the new owner drives the slave in K+2. Minimum gap is therefore 1 idle cycle.
- A request that arrives while the other master owns the bus waits. It is not lost; the master must hold `cyc_i`/`stb_i`.
- A master that lowers `cyc_i` before the ack abandons the access. The FSM returns to IDLE and the ack is dropped.
- Timeout boundary: with `TIMEOUT`=T, `err_o` is asserted in the T-th consecutive cycle of stb without ack. An ack arriving in that same cycle takes precedence: ack=1, err=0, normal completion.
- `grant_o` reads 00 in ABORT_x and the owner's code in OWN_x.

## Test plan
- Reset with both `cyc` high → all outputs 0 and `grant_o`=00. After `rst` rises, D is granted first (`grant_o`=01 one edge later).
- D read at 0x0000_0010, slave acks after 2 wait states returning 0xDEAD_BEEF → `md_data_o`=0xDEAD_BEEF with `md_ack_o`=1 for one cycle; `mi_ack_o` stays 0.
- Both masters hold `cyc` continuously, issuing single accesses → the grant sequence is D, I, D, I, with exactly one IDLE cycle between grants.
- D holds `cyc` for 4 back-to-back strobes, each acked → no re-arbitration; I is granted only after D's `cyc` falls.
- `TIMEOUT`=8, slave never acks an I access → `mi_err_o`=1 in the 8th stb cycle, then ABORT_I. D is not granted until `mi_cyc_i` falls, then IDLE, then OWN_D.
- `rst` pulled low during an OWN_I access with the ack pending → outputs go to 0 asynchronously. A later `s_ack_i` pulse is not forwarded to either master.
